// File: rtl/jk_updown_counter_pkg.sv
// Shared JK excitation encoding and the mapping from a desired bit
// transition to the J/K pair that produces it.
package jk_pkg;

  // {J,K} encoding of the team jkff cell
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLR    = 2'b01,
    JK_TOGGLE = 2'b10,
    JK_SET    = 2'b11
  } jk_t;

  // Counting and holding use toggle/hold so only changing bits are excited.
  // Loading forces set/clear so the result never depends on the current bit.
  function automatic jk_t jk_excite(input logic cur, input logic nxt, input logic load);
    jk_t r;
    if (load) begin
      r = nxt ? JK_SET : JK_CLR;
    end else begin
      r = (cur != nxt) ? JK_TOGGLE : JK_HOLD;
    end
    return r;
  endfunction

endpackage

// File: rtl/jk_updown_counter_jkff.sv
// Single JK flip-flop cell: {J,K} = 00 hold, 10 toggle, 11 set, 01 clear.
module jkff (
  input  logic CLK,
  input  logic RESET,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_reg;

  // Synchronous reset, then apply the JK action
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_reg <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q_reg <= q_reg;
        2'b10:   q_reg <= ~q_reg;
        2'b11:   q_reg <= 1'b1;
        default: q_reg <= 1'b0;
      endcase
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-N up/down counter with parallel load, built from a bank of jkff
// cells. TC is the combinational terminal count for digit cascading, WRAP
// is a registered one-cycle rollover pulse.
module jk_updown_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  // Arithmetic is done one bit wider so MODULUS = 2^WIDTH is representable
  localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] LAST_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(MODULUS - 1);

  logic [WIDTH:0]   cur_ext;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] dn_next;
  logic [WIDTH-1:0] load_next;
  logic [WIDTH-1:0] q_next;
  logic             wrap_reg;

  // Next-count candidates and priority selection LOAD > EN > hold
  always_comb begin
    cur_ext = {1'b0, Q};
    d_ext   = {1'b0, D};
    // Anything at or past the last value (including unreachable states) wraps to 0
    up_next   = (cur_ext >= LAST_EXT) ? '0 : WIDTH'(cur_ext + 1'b1);
    // Out-of-range values simply decrement until they are back in range
    dn_next   = (cur_ext == '0) ? LAST : WIDTH'(cur_ext - 1'b1);
    load_next = (d_ext >= MOD_EXT) ? LAST : D;
    if (LOAD) begin
      q_next = load_next;
    end else if (EN) begin
      q_next = UP ? up_next : dn_next;
    end else begin
      q_next = Q;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_t jk;
      assign jk = jk_excite(Q[gi], q_next[gi], LOAD);
      jkff u_ff (
        .CLK   (CLK),
        .RESET (RESET),
        .j     (jk[1]),
        .k     (jk[0]),
        .q     (Q[gi])
      );
    end
  endgenerate

  // Terminal count: the next enabled edge will roll over
  assign TC = EN & ((UP & (Q == LAST)) | (~UP & (Q == '0)));

  // Rollover pulse, suppressed when a load takes the edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= TC & ~LOAD;
    end
  end

  assign WRAP = wrap_reg;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed testbench for jk_updown_counter: default decade counter, a
// MODULUS=16 instance for the full-range load, and a two-digit cascade.
module tb_jk_updown_counter;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d = 4'd0;
  logic [3:0] q;
  logic       tc;
  logic       wrap;

  logic [3:0] q16;
  logic       tc16;
  logic       wrap16;

  logic       c_en = 1'b0;
  logic [3:0] q0, q1;
  logic       tc0, tc1, w0, w1;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK(CLK), .RESET(rst), .EN(en), .UP(up), .LOAD(load), .D(d),
    .Q(q), .TC(tc), .WRAP(wrap)
  );

  jk_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .CLK(CLK), .RESET(rst), .EN(en), .UP(up), .LOAD(load), .D(d),
    .Q(q16), .TC(tc16), .WRAP(wrap16)
  );

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dig0 (
    .CLK(CLK), .RESET(rst), .EN(c_en), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
    .Q(q0), .TC(tc0), .WRAP(w0)
  );

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dig1 (
    .CLK(CLK), .RESET(rst), .EN(tc0), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
    .Q(q1), .TC(tc1), .WRAP(w1)
  );

  // advance one edge and settle past it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0; c_en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (q !== 4'd0) begin fails++; $display("FAIL reset_q got %0d want 0", q); end
    tests++;
    if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got %b want 0", wrap); end
    tests++;
    if (tc !== 1'b0) begin fails++; $display("FAIL reset_tc_idle got %b want 0", tc); end
    en = 1'b1; up = 1'b0; #1;
    tests++;
    if (tc !== 1'b1) begin fails++; $display("FAIL reset_tc_down got %b want 1", tc); end
    en = 1'b0; up = 1'b1;
    $display("[TB] test_reset done");
  endtask

  task automatic test_count_up();
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      tests++;
      if (q !== 4'(i % 10) || tc !== (i % 10 == 9) || wrap !== (i == 10)) begin
        fails++;
        $display("FAIL count_up[%0d] got q=%0d tc=%b wrap=%b want q=%0d tc=%b wrap=%b",
                 i, q, tc, wrap, i % 10, (i % 10 == 9), (i == 10));
      end
      $display("[TB] up cycle %0d q=%0d tc=%b wrap=%b", i, q, tc, wrap);
      step();
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    do_reset();
    en = 1'b1; up = 1'b0; #1;
    tests++;
    if (tc !== 1'b1) begin fails++; $display("FAIL down_tc0 got %b want 1", tc); end
    step();
    tests++;
    if (q !== 4'd9 || wrap !== 1'b1) begin fails++; $display("FAIL down_9 got q=%0d wrap=%b want q=9 wrap=1", q, wrap); end
    step();
    tests++;
    if (q !== 4'd8 || wrap !== 1'b0 || tc !== 1'b0) begin fails++; $display("FAIL down_8 got q=%0d wrap=%b tc=%b want 8 0 0", q, wrap, tc); end
    step();
    tests++;
    if (q !== 4'd7) begin fails++; $display("FAIL down_7 got %0d want 7", q); end
    en = 1'b0; up = 1'b1;
    $display("[TB] test_count_down done");
  endtask

  task automatic test_load();
    do_reset();
    load = 1'b1; d = 4'd7;
    step();
    tests++;
    if (q !== 4'd7 || wrap !== 1'b0) begin fails++; $display("FAIL load_7 got q=%0d wrap=%b want 7 0", q, wrap); end
    d = 4'd12;
    step();
    tests++;
    if (q !== 4'd9) begin fails++; $display("FAIL load_clamp got %0d want 9", q); end
    d = 4'd15;
    step();
    tests++;
    if (q16 !== 4'd15) begin fails++; $display("FAIL load_mod16 got %0d want 15", q16); end
    tests++;
    if (q !== 4'd9) begin fails++; $display("FAIL load_clamp15 got %0d want 9", q); end
    load = 1'b0;
    $display("[TB] test_load done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    load = 1'b1; d = 4'd9;
    step();
    en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd3; #1;
    tests++;
    if (tc !== 1'b1) begin fails++; $display("FAIL simul_tc got %b want 1", tc); end
    step();
    tests++;
    if (q !== 4'd3 || wrap !== 1'b0) begin fails++; $display("FAIL simul_load got q=%0d wrap=%b want 3 0", q, wrap); end
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (q !== 4'd3 || wrap !== 1'b0) begin fails++; $display("FAIL hold[%0d] got q=%0d wrap=%b want 3 0", i, q, wrap); end
    end
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    load = 1'b1; d = 4'd6;
    step();
    tests++;
    if (q !== 4'd6) begin fails++; $display("FAIL mid_load6 got %0d want 6", q); end
    rst = 1'b1; load = 1'b1; d = 4'd2; en = 1'b1; up = 1'b1;
    step();
    tests++;
    if (q !== 4'd0 || wrap !== 1'b0) begin fails++; $display("FAIL mid_reset got q=%0d wrap=%b want 0 0", q, wrap); end
    rst = 1'b0; load = 1'b0;
    step();
    tests++;
    if (q !== 4'd1) begin fails++; $display("FAIL mid_release got %0d want 1", q); end
    en = 1'b0;
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_cascade();
    do_reset();
    c_en = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      step();
      if (i == 50) begin
        tests++;
        if (q1 !== 4'd5 || q0 !== 4'd0) begin fails++; $display("FAIL cascade_50 got %0d%0d want 50", q1, q0); end
      end
    end
    tests++;
    if (q1 !== 4'd9 || q0 !== 4'd9 || tc1 !== 1'b1) begin fails++; $display("FAIL cascade_99 got %0d%0d tc1=%b want 99 tc1=1", q1, q0, tc1); end
    step();
    tests++;
    if (q1 !== 4'd0 || q0 !== 4'd0 || w0 !== 1'b1 || w1 !== 1'b1) begin
      fails++;
      $display("FAIL cascade_wrap got %0d%0d w0=%b w1=%b want 00 1 1", q1, q0, w0, w1);
    end
    c_en = 1'b0;
    $display("[TB] test_cascade done");
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_simultaneous();
    test_reset_mid();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_updown_counter.md
# jk_updown_counter

Synchronous modulo-N up/down counter whose state is held in a bank of team `jkff` cells. The block computes per-bit J/K excitations from the count direction, enable and parallel-load inputs, and feeds them to the flip-flops directly downstream. It serves as the standard counter stage for timers and BCD digit chains: TC ripples into the next digit's EN, and WRAP reports the rollover.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `MODULUS`, default 10: count range is 0..MODULUS-1. Must satisfy 2 ≤ MODULUS ≤ 2^WIDTH.
- `CLK`  in  1: clock, rising-edge.
- `RESET`  in  1: reset RESET, synchronous, active-high; clock CLK.
- `EN`  in  1: count enable.
- `UP`  in  1: direction. 1 = increment, 0 = decrement.
- `LOAD`  in  1: parallel load request.
- `D`  in  WIDTH: load value.
- `Q`  out  WIDTH: current count, taken straight from the jkff outputs.
- `TC`  out  1: terminal count, combinational.
- `WRAP`  out  1: registered one-cycle pulse marking a completed rollover.

## Operation
- Priority per edge: RESET > LOAD > EN > hold.
- RESET: Q ← 0, WRAP ← 0. RESET is routed to every jkff.
- LOAD: Q ← D when D < MODULUS. Otherwise Q ← MODULUS-1 (clamp). WRAP ← 0. EN and UP are ignored.
- EN=1, UP=1: Q ← Q+1. When Q = MODULUS-1, Q ← 0 instead.
- EN=1, UP=0: Q ← Q-1. When Q = 0, Q ← MODULUS-1 instead.
- EN=0 with no LOAD: Q holds. WRAP ← 0.
- TC = EN & ((UP & Q==MODULUS-1) | (~UP & Q==0)). TC is valid in the same cycle and does not depend on LOAD.
- WRAP ← TC & ~LOAD on each edge, so it is high for exactly the one cycle after the wrapping edge.
- jkff encoding: JK=00 hold, 10 toggle, 11 set, 01 clear.
- Excitation for count and hold:
  - per bit, next ≠ current → 10 (toggle).
  - next = current → 00 (hold).
- Excitation for load:
  - target bit 1 → 11 (set).
  - target bit 0 → 01 (clear).
  - Load never uses toggle, so it does not depend on the current value.
- Next-state arithmetic is computed at WIDTH+1 bits, so no overflow is possible when MODULUS = 2^WIDTH.
- Q out of range (not reachable in normal operation, e.g. forced in simulation):
  - counting up returns it to 0.
  - counting down gives Q-1 until it is back in range.

## Timing
- Latency: one CLK edge from EN, LOAD or RESET to the new Q.
- No handshake. Inputs are sampled on every rising edge.
- Reset values: Q = 0, WRAP = 0. TC follows its equation; with EN=1 and UP=0 it is high right after reset.
- Simultaneous LOAD and EN: load wins, and WRAP stays 0.
- RESET mid-count: Q is 0 after the next edge, regardless of LOAD or EN.
- UP may change in any cycle. TC re-evaluates combinationally.
- Cascading: connecting TC of digit n to EN of digit n+1 gives a single-cycle carry with no extra latency.

## Structure
- Package `jk_pkg` holds:
  - `jk_t` (2-bit) with constants `JK_HOLD`, `JK_TOGGLE`, `JK_SET`, `JK_CLR`.
  - function `jk_excite(cur, nxt, load)` returning `jk_t`.
- Sub-module: `jkff`, generated WIDTH times with shared CLK and RESET.
- Top-level logic: next-state and clamp calculation, excitation mapping, TC, and the WRAP register.

## Test plan
Run all scenarios at the defaults (WIDTH=4, MODULUS=10) unless stated.
- Count up: RESET, then EN=1, UP=1 for 12 cycles.
  - Q = 0,1,…,9,0,1,2.
  - TC is high only while Q=9.
  - WRAP is high for exactly the cycle where Q=0 after the 9.
- Count down: EN=1, UP=0 from reset.
  - Q = 9,8,7.
  - TC is high at Q=0, and WRAP pulses once.
- Load, normal and clamped:
  - D=7, LOAD=1 → Q=7.
  - D=12, LOAD=1 → Q=9.
  - D=15 with MODULUS=16 → Q=15.
- Simultaneous events: Q=9, EN=1, UP=1, LOAD=1, D=3.
  - Q=3 next cycle, WRAP=0.
  - Then EN=0 for 3 cycles → Q holds at 3.
- Reset mid-operation: Q=6, RESET=1 together with LOAD=1, D=2.
  - Q=0 and WRAP=0 next cycle.
  - Release RESET with EN=1 → Q=1.
- Cascade: two instances, TC0→EN1, running up for 100 cycles.
  - Pair reads 99 at cycle 99, then 00 with both WRAPs high.
